bus_responder: RTL and testbench
================================

BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter WORD_W, default 32; data word width.
REQ-002 Parameter ADDR_W, default 9; address width; memory depth 2**ADDR_W words.
REQ-003 Parameter PC_ADDR, default 0; address of the program-counter word, held in the memory array.
REQ-004 Parameter DISP_ADDR, default 1; address of the display register.
REQ-005 Parameter SWITCH_ADDR, default 2; address of the switch input, read-only.
REQ-006 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-007 RESET_N  in  1  asynchronous, active-low reset.
REQ-008 read_clock  in  1  read strobe; a 0->1 transition requests a read.
REQ-009 write_clock  in  1  write strobe; a 0->1 transition requests a write.
REQ-010 read_addr  in  ADDR_W  read address, sampled on the read request.
REQ-011 write_addr  in  ADDR_W  write address, sampled on the write request.
REQ-012 data  in  WORD_W  write data, sampled on the write request.
REQ-013 SW  in  18  board switches: SW[16:0] value, SW[17] hold request.
REQ-014 q  out  WORD_W  read data, registered.
REQ-015 ack  out  1  one-cycle pulse on request completion.
REQ-016 busy  out  1  high while any state other than IDLE is active.
REQ-017 displaying  out  WORD_W  display register, feeds the seven-segment driver.

Function
REQ-018 SHALL register read_clock and write_clock once and detect rises as current=1, previous=0.
REQ-019 SHALL implement states IDLE, WRITE, READ, SW_HOLD, DONE.
REQ-020 IDLE + write rise SHALL latch write_addr/data and go to WRITE.
REQ-021 IDLE + read rise only SHALL latch read_addr and go to READ.
REQ-022 WRITE SHALL store the data into the array, and into displaying when the address is DISP_ADDR; then go to READ if a read is pending, else DONE.
REQ-023 Simultaneous read and write rises SHALL set a pending-read flag; write-then-read order applies, and the read returns the newly written word.
REQ-024 READ, address != SWITCH_ADDR: SHALL load q with the array word and go to DONE; ack 2 cycles after the rise is sampled.
REQ-025 READ, address == SWITCH_ADDR: SHALL load q with zero-extended SW[16:0]; SHALL load displaying with the same value when SW[16:0] != 0.
REQ-026 DONE SHALL pulse ack for exactly one cycle, clear the pending flag, and return to IDLE.
REQ-027 Strobe rises while busy SHALL be ignored, with no queueing beyond the pending-read flag.
REQ-028 Writes to SWITCH_ADDR SHALL update the array word only; the switch read value is unaffected.
REQ-029 Address arithmetic SHALL be unsigned ADDR_W with no wrap logic; every address is valid.
REQ-030 q SHALL hold its value between reads.

Reset
REQ-031 RESET_N=0 SHALL immediately force state=IDLE, q=0, ack=0, busy=0, displaying=0, pending flag=0, and strobe history=0.
REQ-032 Reset mid-operation SHALL abort the operation without ack; an interrupted WRITE may or may not commit.
REQ-033 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-034 Macro SWITCH_HOLD_EN defined: a switch read with SW[17]=1 SHALL enter SW_HOLD, drive displaying=0, and withhold ack until SW[17]=0, then go to DONE.
REQ-035 SWITCH_HOLD_EN undefined: SW[17] SHALL be ignored, SW_HOLD is unreachable, and switch reads complete in READ latency.

Verification
REQ-036 Write 0x0000_00AB to address 5, then read address 5 -> ack after each; q=0x0000_00AB 2 cycles after the read rise.
REQ-037 Write 0x1234 to DISP_ADDR -> displaying=0x1234 on the cycle WRITE completes; array[1]=0x1234.
REQ-038 Simultaneous write 0x77 to address 9 and read of address 9 -> single ack; q=0x77.
REQ-039 SWITCH_HOLD_EN defined, SW=0x2_0005 (SW[17]=1), read SWITCH_ADDR -> busy held and displaying=0 for 10 cycles; drop SW[17] -> ack next, q=5.
REQ-040 Assert RESET_N=0 during READ -> no ack; q=0 and busy=0 immediately; a new read after release completes normally.
REQ-041 Read rise while busy -> ignored, and exactly one ack results.

Source files
------------

// File: rtl/bus_responder_if.sv
// Strobe-driven bus between a host and bus_responder: read/write strobes,
// addresses, write data and switches in; read data, ack, busy and display out.
interface bus_responder_if #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned ADDR_W = 9
);
   logic              read_clock;
   logic              write_clock;
   logic [ADDR_W-1:0] read_addr;
   logic [ADDR_W-1:0] write_addr;
   logic [WORD_W-1:0] data;
   logic [17:0]       SW;
   logic [WORD_W-1:0] q;
   logic              ack;
   logic              busy;
   logic [WORD_W-1:0] displaying;

   modport master (
      output read_clock, write_clock, read_addr, write_addr, data, SW,
      input  q, ack, busy, displaying
   );

   modport slave (
      input  read_clock, write_clock, read_addr, write_addr, data, SW,
      output q, ack, busy, displaying
   );
endinterface

// File: rtl/bus_responder.sv
// Memory-mapped word store with a display register and a read-only switch port,
// driven by edge-detected read/write strobes. Define SWITCH_HOLD_EN to let SW[17] stall switch reads.
module bus_responder #(
   parameter int unsigned WORD_W      = 32,
   parameter int unsigned ADDR_W      = 9,
   parameter int unsigned PC_ADDR     = 0,
   parameter int unsigned DISP_ADDR   = 1,
   parameter int unsigned SWITCH_ADDR = 2
) (
   input logic             CLOCK_50,
   input logic             RESET_N,
   bus_responder_if.slave  bus
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] DISP_A = ADDR_W'(DISP_ADDR);
   localparam logic [ADDR_W-1:0] SW_A   = ADDR_W'(SWITCH_ADDR);

   // The special words must sit inside the array and must not overlap each other.
   if (PC_ADDR >= DEPTH || DISP_ADDR >= DEPTH || SWITCH_ADDR >= DEPTH ||
       PC_ADDR == DISP_ADDR || PC_ADDR == SWITCH_ADDR || DISP_ADDR == SWITCH_ADDR) begin : g_bad_map
      $error("bus_responder: invalid address map");
   end

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      SW_HOLD,
      DONE
   } state_t;

   state_t            state;
   logic              rd_cur, rd_prev, wr_cur, wr_prev;
   logic              pending_rd;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic [WORD_W-1:0] wr_data;
   logic [WORD_W-1:0] q_r;
   logic              ack_r;
   logic              busy_r;
   logic [WORD_W-1:0] disp_r;
   logic [WORD_W-1:0] mem [DEPTH];

   logic              rd_rise;
   logic              wr_rise;
   logic [16:0]       sw_val;
   logic [WORD_W-1:0] sw_word;
   logic              hold_req;

   assign rd_rise = rd_cur & ~rd_prev;
   assign wr_rise = wr_cur & ~wr_prev;
   assign sw_val  = bus.SW[16:0];
   assign sw_word = WORD_W'(sw_val);

`ifdef SWITCH_HOLD_EN
   assign hold_req = bus.SW[17];
`else
   assign hold_req = 1'b0;
`endif

   assign bus.q          = q_r;
   assign bus.ack        = ack_r;
   assign bus.busy       = busy_r;
   assign bus.displaying = disp_r;

   // NOTE: the array has no reset so it maps onto plain RAM; its contents survive RESET_N.
   always_ff @(posedge CLOCK_50) begin
      if (state == WRITE) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // NOTE: every register here uses <= so all of them update from pre-edge values,
   // which is what makes the one-stage strobe history a true rise detector.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= IDLE;
         rd_cur     <= 1'b0;
         rd_prev    <= 1'b0;
         wr_cur     <= 1'b0;
         wr_prev    <= 1'b0;
         pending_rd <= 1'b0;
         rd_addr    <= '0;
         wr_addr    <= '0;
         wr_data    <= '0;
         q_r        <= '0;
         ack_r      <= 1'b0;
         busy_r     <= 1'b0;
         disp_r     <= '0;
      end else begin
         rd_cur  <= bus.read_clock;
         rd_prev <= rd_cur;
         wr_cur  <= bus.write_clock;
         wr_prev <= wr_cur;
         ack_r   <= 1'b0;

         case (state)
            IDLE: begin
               // Rises seen outside IDLE are dropped; only a read coinciding with a write is kept.
               if (wr_rise) begin
                  wr_addr    <= bus.write_addr;
                  wr_data    <= bus.data;
                  pending_rd <= rd_rise;
                  if (rd_rise) begin
                     rd_addr <= bus.read_addr;
                  end
                  state  <= WRITE;
                  busy_r <= 1'b1;
               end else if (rd_rise) begin
                  rd_addr <= bus.read_addr;
                  state   <= READ;
                  busy_r  <= 1'b1;
               end
            end

            WRITE: begin
               if (wr_addr == DISP_A) begin
                  disp_r <= wr_data;
               end
               if (pending_rd) begin
                  state <= READ;
               end else begin
                  ack_r <= 1'b1;
                  state <= DONE;
               end
            end

            READ: begin
               if (rd_addr == SW_A) begin
                  q_r <= sw_word;
                  if (hold_req) begin
                     disp_r <= '0;
                     state  <= SW_HOLD;
                  end else begin
                     if (sw_val != '0) begin
                        disp_r <= sw_word;
                     end
                     ack_r <= 1'b1;
                     state <= DONE;
                  end
               end else begin
                  q_r   <= mem[rd_addr];
                  ack_r <= 1'b1;
                  state <= DONE;
               end
            end

            SW_HOLD: begin
               disp_r <= '0;
               if (!hold_req) begin
                  ack_r <= 1'b1;
                  state <= DONE;
               end
            end

            DONE: begin
               pending_rd <= 1'b0;
               busy_r     <= 1'b0;
               state      <= IDLE;
            end

            default: begin
               pending_rd <= 1'b0;
               busy_r     <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: stimulus pushes the expected q of each
// acknowledged request, a negedge monitor pops and compares on every ack.
module tb_bus_responder;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned ADDR_W = 9;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bus_responder_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

   bus_responder #(
      .WORD_W(WORD_W), .ADDR_W(ADDR_W),
      .PC_ADDR(0), .DISP_ADDR(1), .SWITCH_ADDR(2)
   ) dut (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .bus      (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];
   logic [31:0] last_q     = '0;
   logic [31:0] disp_model = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every ack must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && bus.ack) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack=1 (q=0x%0h), expected no ack at %0t", bus.q, $time);
         end else begin
            check("ack_q", bus.q, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ack(input string name, input int exp_lat);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.ack && n < 30);
      check({name, "_latency"}, n, exp_lat);
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
      bus.write_addr = addr;
      bus.data       = wdata;
      if (addr == 1) disp_model = wdata;
      exp_q.push_back(last_q);
      bus.write_clock = 1'b1;
      wait_ack("write", 4);
      check("write_disp", bus.displaying, disp_model);
      bus.write_clock = 1'b0;
      tick();
      tick();
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [31:0] expv);
      bus.read_addr = addr;
      exp_q.push_back(expv);
      last_q = expv;
      bus.read_clock = 1'b1;
      wait_ack("read", 4);
      bus.read_clock = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      int n;
      bus.read_clock  = 1'b0;
      bus.write_clock = 1'b0;
      bus.read_addr   = '0;
      bus.write_addr  = '0;
      bus.data        = '0;
      bus.SW          = '0;

      repeat (3) tick();
      check("reset_q", bus.q, 32'h0);
      check("reset_ack", {31'b0, bus.ack}, 32'h0);
      check("reset_busy", {31'b0, bus.busy}, 32'h0);
      check("reset_disp", bus.displaying, 32'h0);
      rst_n = 1'b1;
      tick();
      tick();

      // Plain write then read back
      do_write(9'd5, 32'h0000_00AB);
      do_read(9'd5, 32'h0000_00AB);

      // Display register write
      do_write(9'd1, 32'h0000_1234);
      check("disp_after_write", bus.displaying, 32'h0000_1234);
      do_read(9'd1, 32'h0000_1234);

      // Simultaneous write and read of the same address: one ack, new data
      bus.write_addr = 9'd9;
      bus.data       = 32'h77;
      bus.read_addr  = 9'd9;
      exp_q.push_back(32'h77);
      last_q = 32'h77;
      bus.write_clock = 1'b1;
      bus.read_clock  = 1'b1;
      wait_ack("simul", 5);
      check("simul_disp", bus.displaying, disp_model);
      bus.write_clock = 1'b0;
      bus.read_clock  = 1'b0;
      repeat (4) tick();

      // Switch reads
`ifdef SWITCH_HOLD_EN
      bus.SW    = 18'h2_0005;
      bus.read_addr = 9'd2;
      exp_q.push_back(32'h5);
      last_q = 32'h5;
      disp_model = 32'h0;
      bus.read_clock = 1'b1;
      repeat (3) tick();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_busy", {31'b0, bus.busy}, 32'h1);
         check("hold_disp", bus.displaying, 32'h0);
         check("hold_no_ack", {31'b0, bus.ack}, 32'h0);
      end
      bus.SW = 18'h0_0005;
      wait_ack("hold_release", 1);
      bus.read_clock = 1'b0;
      tick();
      tick();
      check("hold_disp_after", bus.displaying, disp_model);
`else
      bus.SW = 18'h2_0005;
      do_read(9'd2, 32'h5);
      disp_model = 32'h5;
      check("switch_disp", bus.displaying, disp_model);
`endif
      bus.SW = 18'h0;
      do_read(9'd2, 32'h0);
      check("switch_zero_disp", bus.displaying, disp_model);

      // A write to the switch address does not shadow the switches
      bus.SW = 18'h0_00C3;
      do_write(9'd2, 32'h0000_DEAD);
      do_read(9'd2, 32'h0000_00C3);
      disp_model = 32'h0000_00C3;
      check("switch_after_write_disp", bus.displaying, disp_model);

      // Reset in the middle of a read
      bus.read_addr  = 9'd5;
      bus.read_clock = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.busy && n < 20);
      check("reset_mid_busy_seen", {31'b0, bus.busy}, 32'h1);
      #1;
      rst_n = 1'b0;
      bus.read_clock = 1'b0;
      #1;
      check("abort_q", bus.q, 32'h0);
      check("abort_busy", {31'b0, bus.busy}, 32'h0);
      check("abort_ack", {31'b0, bus.ack}, 32'h0);
      check("abort_disp", bus.displaying, 32'h0);
      last_q = 32'h0;
      disp_model = 32'h0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      do_read(9'd5, 32'h0000_00AB);

      // Read rise while busy with a write: ignored, exactly one ack
      bus.write_addr = 9'd7;
      bus.data       = 32'h55;
      exp_q.push_back(last_q);
      bus.write_clock = 1'b1;
      tick();
      bus.read_addr  = 9'd9;
      bus.read_clock = 1'b1;
      wait_ack("busy_write", 3);
      bus.write_clock = 1'b0;
      bus.read_clock  = 1'b0;
      repeat (6) tick();
      check("scoreboard_drained", exp_q.size(), 32'h0);
      do_read(9'd7, 32'h55);
      repeat (3) tick();
      check("scoreboard_final", exp_q.size(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
